// File: rtl/alu_issue.sv
// alu_issue: registered decode/issue stage in front of the combinational ALU.
//
// Takes one RV32I instruction per cycle together with its register-file
// operands and PC, decodes it into a 4-bit ALU opcode plus final A/B operands,
// and presents the result through a valid/ready handshake. A main register
// plus a skid register give full throughput under backpressure.
//
// Ports:
//   clk          clock, all state on the rising edge
//   rst_n        synchronous active-low reset
//   flush        synchronous discard of all buffered entries
//   in_valid     upstream offers an instruction
//   in_ready     stage can accept this cycle
//   in_instr     raw RV32I instruction word
//   in_pc        PC of in_instr
//   in_rs1_data  rs1 value
//   in_rs2_data  rs2 value
//   out_valid    decoded entry available
//   out_ready    downstream consumes this cycle
//   out_alu_op   ALU opcode
//   out_a_data   ALU operand A
//   out_b_data   ALU operand B
//   out_rd       destination register field, instr[11:7]
//   out_illegal  unsupported encoding
module alu_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_alu_op,
  output logic [31:0] out_a_data,
  output logic [31:0] out_b_data,
  output logic [4:0]  out_rd,
  output logic        out_illegal
);

  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] OpcLui   = 7'b0110111;
  localparam logic [6:0] OpcAuipc = 7'b0010111;
  localparam logic [6:0] OpcLoad  = 7'b0000011;
  localparam logic [6:0] OpcStore = 7'b0100011;

  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSll  = 4'b0100;
  localparam logic [3:0] AluSrl  = 4'b0110;
  localparam logic [3:0] AluAnd  = 4'b1001;
  localparam logic [3:0] AluOr   = 4'b1010;
  localparam logic [3:0] AluXor  = 4'b1011;
  localparam logic [3:0] AluSltu = 4'b1100;
  localparam logic [3:0] AluSlt  = 4'b1101;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        ill;
  } entry_t;

  // funct3 to ALU opcode for the register/immediate forms. sub and sra are
  // obtained by setting bit 0 of add and srl respectively.
  function automatic logic [3:0] base_op(input logic [2:0] f3);
    logic [3:0] op;
    case (f3)
      3'b000:  op = AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_u;
  logic [31:0] shamt;
  logic        alt;
  logic        is_shift;
  logic        legal;
  entry_t      dec;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign funct7   = in_instr[31:25];
  assign imm_i    = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s    = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_u    = {in_instr[31:12], 12'h000};
  assign shamt    = {27'b0, in_instr[24:20]};
  assign alt      = (funct7 == 7'h20);
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // Decode of the incoming instruction.
  always_comb begin
    dec    = '0;
    legal  = 1'b1;
    dec.rd = in_instr[11:7];
    case (opcode)
      OpcOp: begin
        dec.a  = in_rs1_data;
        dec.b  = in_rs2_data;
        // funct7 0x20 is only meaningful for add->sub and srl->sra.
        legal  = (funct7 == 7'h00) || (alt && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        dec.op = base_op(funct3) | {3'b000, alt};
      end
      OpcOpImm: begin
        dec.a  = in_rs1_data;
        dec.b  = is_shift ? shamt : imm_i;
        // Non-shift forms carry immediate bits in funct7, so only shifts check it.
        legal  = !is_shift || (funct7 == 7'h00) || (alt && (funct3 == 3'b101));
        dec.op = base_op(funct3) | {3'b000, is_shift & alt};
      end
      OpcLui: begin
        dec.op = AluAdd;
        dec.b  = imm_u;
      end
      OpcAuipc: begin
        dec.op = AluAdd;
        dec.a  = in_pc;
        dec.b  = imm_u;
      end
      OpcLoad: begin
        dec.op = AluAdd;
        dec.a  = in_rs1_data;
        dec.b  = imm_i;
      end
      OpcStore: begin
        dec.op = AluAdd;
        dec.a  = in_rs1_data;
        dec.b  = imm_s;
      end
      default: legal = 1'b0;
    endcase
    // Illegal entries still flow in order, with neutral operands.
    if (!legal) begin
      dec.op = AluAdd;
      dec.a  = '0;
      dec.b  = '0;
    end
    dec.ill = !legal;
  end

  // Two-entry buffer: main drives the outputs, skid catches the one extra
  // entry accepted in the cycle the downstream stalls.
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q, in_ready_d;
  logic   push;
  logic   pop;

  assign in_ready = in_ready_q & rst_n;
  assign push     = in_valid & in_ready & ~flush;
  assign pop      = main_valid_q & out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (pop) begin
      if (skid_valid_q) begin
        // in_ready is low whenever skid holds an entry, so no push here.
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (push) begin
        main_d = dec;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (push) begin
      if (main_valid_q) begin
        skid_d       = dec;
        skid_valid_d = 1'b1;
      end else begin
        main_d       = dec;
        main_valid_d = 1'b1;
      end
    end
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign out_valid   = main_valid_q;
  assign out_alu_op  = main_q.op;
  assign out_a_data  = main_q.a;
  assign out_b_data  = main_q.b;
  assign out_rd      = main_q.rd;
  assign out_illegal = main_q.ill;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed decode/handshake cases with
// literal expectations, then randomized traffic against a queue-based model.
module tb_alu_issue;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_alu_op;
  logic [31:0] out_a_data;
  logic [31:0] out_b_data;
  logic [4:0]  out_rd;
  logic        out_illegal;

  alu_issue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .in_rs1_data (in_rs1_data),
    .in_rs2_data (in_rs2_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_alu_op  (out_alu_op),
    .out_a_data  (out_a_data),
    .out_b_data  (out_b_data),
    .out_rd      (out_rd),
    .out_illegal (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  exp_t shown;
  bit   started  = 1'b0;
  bit   init_ok  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Reference decode from the ISA tables.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] r1, input logic [31:0] r2);
    logic [3:0]  f3_tab [8];
    exp_t        e;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;
    logic        ok;
    logic        shift;
    f3_tab = '{4'h0, 4'h4, 4'hD, 4'hC, 4'hB, 4'h6, 4'hA, 4'h9};
    f3     = ins[14:12];
    f7     = ins[31:25];
    imm_i  = 32'($signed(ins[31:20]));
    imm_s  = 32'($signed({ins[31:25], ins[11:7]}));
    imm_u  = {ins[31:12], 12'h000};
    e      = '0;
    e.rd   = ins[11:7];
    ok     = 1'b1;
    case (ins[6:0])
      7'h33: begin
        ok   = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        e.op = f3_tab[f3] + {3'b000, f7 == 7'h20};
        e.a  = r1;
        e.b  = r2;
      end
      7'h13: begin
        shift = (f3 == 3'd1) || (f3 == 3'd5);
        ok    = !shift || (f7 == 7'h00) || (f7 == 7'h20 && f3 == 3'd5);
        e.op  = f3_tab[f3] + {3'b000, shift && f7 == 7'h20};
        e.a   = r1;
        e.b   = shift ? {27'b0, ins[24:20]} : imm_i;
      end
      7'h37: e.b = imm_u;
      7'h17: begin e.a = pc; e.b = imm_u; end
      7'h03: begin e.a = r1; e.b = imm_i; end
      7'h23: begin e.a = r1; e.b = imm_s; end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e.op = 4'h0;
      e.a  = '0;
      e.b  = '0;
    end
    e.ill = !ok;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  f7;
    int          k;
    int          s;
    w = $urandom;
    k = $urandom_range(0, 9);
    s = $urandom_range(0, 3);
    f7 = (s < 2) ? 7'h00 : (s == 2) ? 7'h20 : 7'($urandom);
    case (k)
      0, 1: begin w[6:0] = 7'h33; w[31:25] = f7; end
      2, 3: begin w[6:0] = 7'h13; w[31:25] = f7; end
      4: w[6:0] = 7'h37;
      5: w[6:0] = 7'h17;
      6: w[6:0] = 7'h03;
      7: w[6:0] = 7'h23;
      default: ;
    endcase
    return w;
  endfunction

  function automatic bit model_ready();
    return rst_n && init_ok && (exp_q.size() < 2);
  endfunction

  // Mid-cycle comparison of every output against the model.
  task automatic sample();
    exp_t e;
    #4;
    if (started) begin
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(model_ready()));
      e = (exp_q.size() > 0) ? exp_q[0] : shown;
      chk("alu_op", 32'(out_alu_op), 32'(e.op));
      chk("a_data", out_a_data, e.a);
      chk("b_data", out_b_data, e.b);
      chk("rd", 32'(out_rd), 32'(e.rd));
      chk("illegal", 32'(out_illegal), 32'(e.ill));
      if (exp_q.size() > 0) shown = exp_q[0];
    end
  endtask

  // Clock edge with the model stepping in lockstep.
  task automatic advance();
    bit   do_push;
    bit   do_pop;
    exp_t e;
    do_push = in_valid && model_ready() && !flush;
    do_pop  = (exp_q.size() > 0) && out_ready;
    e       = ref_decode(in_instr, in_pc, in_rs1_data, in_rs2_data);
    @(posedge clk);
    if (!rst_n) begin
      exp_q.delete();
      shown   = '0;
      init_ok = 1'b0;
    end else begin
      init_ok = 1'b1;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) exp_q.push_back(e);
      end
    end
    started = 1'b1;
    #1;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  task automatic set_in(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] r1, input logic [31:0] r2);
    in_valid    = v;
    in_instr    = ins;
    in_pc       = pc;
    in_rs1_data = r1;
    in_rs2_data = r2;
  endtask

  // Issue one instruction with out_ready high, then check the next cycle
  // against literal values.
  task automatic issue(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                       input logic ill);
    out_ready = 1'b1;
    set_in(1'b1, ins, pc, r1, r2);
    cycle();
    set_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    sample();
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".op"}, 32'(out_alu_op), 32'(op));
    chk({tag, ".a"}, out_a_data, a);
    chk({tag, ".b"}, out_b_data, b);
    chk({tag, ".rd"}, 32'(out_rd), 32'(rd));
    chk({tag, ".ill"}, 32'(out_illegal), 32'(ill));
    advance();
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    set_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    repeat (3) cycle();
    sample();
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.op", 32'(out_alu_op), 32'd0);
    chk("rst.a", out_a_data, 32'd0);
    advance();
    rst_n = 1'b1;
    cycle();
    sample();
    chk("post_rst.in_ready", 32'(in_ready), 32'd1);
    advance();

    // Decode cases.
    issue("add", 32'h002081B3, 32'h0, 32'd5, 32'd7, 4'h0, 32'd5, 32'd7, 5'd3, 1'b0);
    issue("sub", 32'h402081B3, 32'h0, 32'd5, 32'd7, 4'h1, 32'd5, 32'd7, 5'd3, 1'b0);
    issue("addi", 32'hFFF00293, 32'h0, 32'd0, 32'd9, 4'h0, 32'd0, 32'hFFFFFFFF, 5'd5, 1'b0);
    issue("srai", 32'h4040D313, 32'h0, 32'h80000000, 32'd0, 4'h7, 32'h80000000, 32'd4, 5'd6,
          1'b0);
    issue("lui", 32'h123450B7, 32'h44, 32'd1, 32'd2, 4'h0, 32'd0, 32'h12345000, 5'd1, 1'b0);
    issue("auipc", 32'h12345097, 32'h100, 32'd1, 32'd2, 4'h0, 32'h100, 32'h12345000, 5'd1, 1'b0);
    issue("sw", 32'h0020A423, 32'h0, 32'h1000, 32'd3, 4'h0, 32'h1000, 32'd8, 5'd8, 1'b0);
    issue("ill_opc", 32'hFFFFFFFF, 32'h0, 32'd5, 32'd7, 4'h0, 32'd0, 32'd0, 5'd31, 1'b1);
    issue("ill_f7", 32'h022081B3, 32'h0, 32'd5, 32'd7, 4'h0, 32'd0, 32'd0, 5'd3, 1'b1);
    cycle();
    sample();
    chk("empty.valid", 32'(out_valid), 32'd0);
    chk("empty.hold_rd", 32'(out_rd), 32'd3);
    advance();

    // Backpressure: three back-to-back pushes with the sink stalled.
    out_ready = 1'b0;
    set_in(1'b1, 32'h000000B3, 32'h0, 32'd1, 32'd1);
    cycle();
    set_in(1'b1, 32'h00000133, 32'h0, 32'd2, 32'd2);
    cycle();
    set_in(1'b1, 32'h000001B3, 32'h0, 32'd3, 32'd3);
    sample();
    chk("full.in_ready", 32'(in_ready), 32'd0);
    chk("full.rd", 32'(out_rd), 32'd1);
    advance();
    sample();
    chk("stall.rd", 32'(out_rd), 32'd1);
    chk("stall.a", out_a_data, 32'd1);
    out_ready = 1'b1;
    advance();
    sample();
    chk("drain1.rd", 32'(out_rd), 32'd2);
    chk("drain1.in_ready", 32'(in_ready), 32'd1);
    advance();
    set_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    sample();
    chk("drain2.rd", 32'(out_rd), 32'd3);
    advance();
    sample();
    chk("drain3.valid", 32'(out_valid), 32'd0);
    advance();

    // Flush with a simultaneous input.
    out_ready = 1'b0;
    set_in(1'b1, 32'h000000B3, 32'h0, 32'd11, 32'd1);
    cycle();
    cycle();
    flush = 1'b1;
    set_in(1'b1, 32'h000004B3, 32'h0, 32'd99, 32'd1);
    cycle();
    flush = 1'b0;
    set_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    out_ready = 1'b1;
    sample();
    chk("flush.valid", 32'(out_valid), 32'd0);
    chk("flush.in_ready", 32'(in_ready), 32'd1);
    advance();
    sample();
    chk("flush.valid2", 32'(out_valid), 32'd0);
    advance();

    // Reset mid-stall.
    out_ready = 1'b0;
    set_in(1'b1, 32'h000000B3, 32'h0, 32'd5, 32'd6);
    cycle();
    cycle();
    rst_n = 1'b0;
    cycle();
    sample();
    chk("rst2.valid", 32'(out_valid), 32'd0);
    chk("rst2.in_ready", 32'(in_ready), 32'd0);
    chk("rst2.op", 32'(out_alu_op), 32'd0);
    chk("rst2.a", out_a_data, 32'd0);
    chk("rst2.b", out_b_data, 32'd0);
    chk("rst2.rd", 32'(out_rd), 32'd0);
    chk("rst2.ill", 32'(out_illegal), 32'd0);
    advance();
    rst_n = 1'b1;
    set_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    cycle();
    sample();
    chk("rst2.ready_after", 32'(in_ready), 32'd1);
    advance();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      rst_n     = ($urandom_range(0, 149) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      out_ready = ($urandom_range(0, 9) < 6);
      set_in(1'($urandom_range(0, 9) < 7), rand_instr(), $urandom, $urandom, $urandom);
      cycle();
    end
    rst_n = 1'b1;
    flush = 1'b0;
    set_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    out_ready = 1'b1;
    repeat (4) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Registered decode/issue stage that drives the ALU's operand and opcode interface. It accepts one RV32I instruction per cycle with its register-file operands and PC, decodes it into the 4-bit ALU opcode plus the final A/B operands, and presents them through a valid/ready handshake. It sits between register read and the combinational ALU. A 2-entry skid buffer keeps full throughput under backpressure.

## Interface
Parameters:
- none; datapath fixed at 32 bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- flush  in  1  synchronous discard of all buffered entries.
- in_valid  in  1  upstream offers an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  32  raw RV32I instruction word.
- in_pc  in  32  PC of in_instr.
- in_rs1_data  in  32  value of rs1.
- in_rs2_data  in  32  value of rs2.
- out_valid  out  1  decoded entry available.
- out_ready  in  1  downstream consumes this cycle.
- out_alu_op  out  4  ALU opcode (encoding below).
- out_a_data  out  32  ALU operand A.
- out_b_data  out  32  ALU operand B.
- out_rd  out  5  destination register, instr[11:7].
- out_illegal  out  1  unsupported encoding.

## Operation
- ALU opcodes: 0000 add, 0001 sub, 0100 sll, 0110 srl, 0111 sra, 1001 and, 1010 or, 1011 xor, 1100 sltu, 1101 slt.
- OP (0110011): A=rs1, B=rs2. funct3 000→add (funct7 0x00) / sub (0x20); 001→sll; 010→slt; 011→sltu; 100→xor; 101→srl (0x00) / sra (0x20); 110→or; 111→and. Any other funct7 → illegal.
- OP-IMM (0010011): A=rs1, B=sign-extended instr[31:20]. Same funct3 map, no sub. Shifts use B={27'b0, instr[24:20]}. srai needs funct7 0x20 and slli/srli need 0x00, else illegal.
- LUI (0110111): A=0, B={instr[31:12],12'b0}, add.
- AUIPC (0010111): A=in_pc, B={instr[31:12],12'b0}, add.
- LOAD (0000011): A=rs1, B=sign-ext I-imm, add.
- STORE (0100011): A=rs1, B=sign-ext {instr[31:25],instr[11:7]}, add. out_rd = instr[11:7] unchanged; the consumer ignores it.
- Any other opcode: out_illegal=1, alu_op=0000, A=B=0; the entry still flows through in order.
- Buffer: main register plus skid register. A transfer occurs when valid&ready on that side.
- in_ready = !skid_valid, registered. It is forced to 0 while rst_n=0.
- The entry is accepted while the main register is full and out_ready=0 → goes to skid. On the next pop the skid moves to main.
- Output fields change only when out_valid=0 or a pop occurred in the previous cycle. They are held stable while out_valid&!out_ready.
- flush=1: main_valid and skid_valid clear at the edge. A simultaneous in_valid is dropped, not accepted.

## Timing
- Latency: an input accepted at edge N shows on the outputs after edge N (out_valid high in cycle N+1).
- Throughput: 1 instruction/cycle with out_ready held high.
- Reset (rst_n low at an edge): out_valid=0, in_ready=0 during reset and 1 the cycle after. out_alu_op=0, out_a_data=0, out_b_data=0, out_rd=0, out_illegal=0, and both entries are invalid.
- Full: both entries valid → in_ready=0 the next cycle. Pop and push in the same cycle keep occupancy constant.
- Empty: a pop with no push → out_valid=0 next cycle. Outputs hold their last values.
- Order is strictly FIFO. No entry is duplicated or dropped except by flush or reset.
- Reset or flush mid-stall: all entries are discarded, in_ready=1 the next cycle (reset: cycle after deassertion).

## Test plan
- add x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 → next cycle: op 0000, A=5, B=7, rd=3, illegal=0. Repeat with sub 0x402081B3 → op 0001.
- addi x5,x0,-1 (0xFFF00293), rs1=0 → A=0, B=0xFFFFFFFF, op 0000. srai x6,x1,4 (0x4040D313), rs1=0x80000000 → op 0111, B=4, rd=6.
- lui x1,0x12345 (0x123450B7) → A=0, B=0x12345000. auipc with pc=0x100 and the same imm → A=0x100, add.
- 0xFFFFFFFF → illegal=1, op 0000, A=B=0. Also OP with funct7=0x01 → illegal=1.
- out_ready=0, push 3 back-to-back: first two accepted, in_ready=0 on the third, outputs stable. Then out_ready=1 → all 3 emerge in order, one per cycle.
- Two entries buffered, flush=1 together with in_valid=1 → next cycle out_valid=0, nothing from that input appears. Repeat with rst_n=0 instead → all outputs 0.
